hs_rr_arbiter: RTL and testbench
================================

# hs_rr_arbiter

Round-robin arbiter that lets `NUM_REQ` valid/ready producers share one 8-bit valid/ready output channel, the same handshake the `top` data port uses. Each cycle the output register can load, it grants one requester, accepts one beat from it, and presents that beat on the shared channel one cycle later. It sits between the per-source producers and the single downstream consumer, and adds a source tag so the consumer can demultiplex.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DW`, 8: data width.
- `MAX_BURST`, 4: beats a granted requester may hold the grant for, 1..15. Used only with `ARB_BURST_LOCK_EN`.
- `clk` in 1: single clock; every flop is clocked on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in `NUM_REQ`: per-requester valid.
- `in_data` in `NUM_REQ*DW`: requester i occupies bits [i*DW +: DW].
- `in_ready` out `NUM_REQ`: one-hot or zero; combinational.
- `out_valid` out 1: shared channel valid, registered.
- `out_data` out `DW`: shared channel data, registered.
- `out_src` out `clog2(NUM_REQ)` (minimum 1): index of the requester that supplied `out_data`.
- `out_ready` in 1: downstream ready.

## Operation
- `load = !out_valid || out_ready`. The arbiter grants only when `load` is 1.
- Search order is `ptr+1, ptr+2, …` modulo `NUM_REQ`. The first requester in that order with `in_valid` high wins.
- `in_ready[win] = load`; all other `in_ready` bits are 0. A beat transfers when `in_valid[i] && in_ready[i]`.
- On transfer, `out_data`, `out_src` and `out_valid=1` register on the next edge, and `ptr <= win`.
- If `load` is 1 and no requester is valid, `out_valid <= 0`, and `out_data`/`out_src` hold their values.
- While `out_valid && !out_ready`: all `in_ready` bits are 0 and the output registers hold. This is the stall rule: `out_data` is stable while valid is high.
- Reset values: `out_valid=0`, `out_data=0`, `out_src=0`, `ptr=NUM_REQ-1` so requester 0 has first priority, burst count 0, FSM state IDLE.
- While `rst` is high, `in_ready` is forced to 0.
- Reset asserted mid-transfer drops the registered beat with no flush handshake.
- Requesters must hold `in_valid`/`in_data` until accepted. The arbiter does not check this.

## Timing
- Latency: a beat accepted at edge N appears on `out_valid`/`out_data` after edge N.
- Throughput: 1 beat/cycle when `out_ready` is held at 1.
- Back-to-back grants to different requesters are legal on consecutive cycles.
- `in_ready` is a combinational function of `in_valid`, `out_valid`, `out_ready`, `ptr` and the FSM state. There is no combinational path from `in_data` to any output.
- Simultaneous `out_ready` consumption and a new grant in the same cycle is the normal pipelined case; no bubble is inserted.
- `ptr` wraps from `NUM_REQ-1` to 0.

## Configuration
- Macro `ARB_BURST_LOCK_EN`.
- Defined:
  - The FSM has two states, IDLE and LOCK, and a 4-bit burst counter `bcnt`.
  - A grant taken in IDLE moves the FSM to LOCK with `bcnt=1`.
  - In LOCK, the locked requester (`ptr`) wins whenever `load && in_valid[ptr]`, and `bcnt` increments.
  - LOCK returns to IDLE when `bcnt==MAX_BURST` after a transfer, or when `load && !in_valid[ptr]`. In the second case round-robin search starts from `ptr+1` in that same cycle.
  - A stall (`!load`) holds both state and `bcnt`.
- Undefined: per-beat round-robin only. The FSM and counter are not instantiated.

## Test plan
- Reset, then all `in_valid=0`, `out_ready=1` -> `out_valid=0`, `in_ready=0000`, `out_data=0x00`.
- Only requester 2 valid with data 0x5A, `out_ready=1` -> `in_ready=0100`; next cycle `out_valid=1`, `out_data=0x5A`, `out_src=2`.
- All four requesters valid continuously, `out_ready=1`, macro off, data = index -> `out_src` sequence 0,1,2,3,0,1 with no idle cycles.
- Same as previous, but with `out_ready=0` for 3 cycles after the first beat -> `out_data` holds 0x00 with `out_valid=1`, `in_ready=0000`; the sequence resumes at 1 when ready returns.
- With `ARB_BURST_LOCK_EN`, `MAX_BURST=4`, all valid -> `out_src` 0,0,0,0,1,1,1,1,2…. Requester 1 dropping valid after 2 beats -> the next grant goes to 2 with no bubble.
- Assert `rst` for 1 cycle while `out_valid=1` and stalled -> next cycle `out_valid=0`; the first grant after reset goes to requester 0.

Source files
------------

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter: NUM_REQ valid/ready producers share one registered DW-bit output channel tagged with out_src.
// Latency: a beat accepted on edge N is presented on out_valid/out_data/out_src after edge N (1 cycle).
// Backpressure: out_valid && !out_ready freezes the output register and drops every in_ready; optional ARB_BURST_LOCK_EN holds the grant for up to MAX_BURST beats.
module hs_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [NUM_REQ-1:0]                                in_valid,
    input  logic [NUM_REQ*DW-1:0]                             in_data,
    output logic [NUM_REQ-1:0]                                in_ready,
    output logic                                              out_valid,
    output logic [DW-1:0]                                     out_data,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]  out_src,
    input  logic                                              out_ready
);

    localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Reject out-of-range configurations at elaboration time.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("hs_rr_arbiter: NUM_REQ must be 2..8");
    end
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
        $error("hs_rr_arbiter: MAX_BURST must be 1..15");
    end

    // The output register may take a new beat when empty or being drained this cycle.
    logic          load;
    logic [SW-1:0] ptr;        // last granted requester; search starts just after it
    logic [SW-1:0] rr_win;
    logic          rr_found;
    logic [SW-1:0] win;
    logic          win_found;
    logic          xfer;
    logic [DW-1:0] win_data;

    assign load = !out_valid || out_ready;

    // Round-robin search ptr+1, ptr+2, ... ptr (mod NUM_REQ); walking backwards lets the nearest hit overwrite.
    always_comb begin
        int            idx_int;
        logic [SW-1:0] idx;
        rr_win   = '0;
        rr_found = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx_int = (int'(ptr) + k) % NUM_REQ;
            idx     = idx_int[SW-1:0];
            if (in_valid[idx]) begin
                rr_found = 1'b1;
                rr_win   = idx;
            end
        end
    end

`ifdef ARB_BURST_LOCK_EN
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0] state;
    logic [3:0] bcnt;
    logic [3:0] bcnt_nxt;
    logic       lock_hit;

    // While locked, the owner keeps the grant as long as it still has data; otherwise fall back to round-robin.
    always_comb begin
        lock_hit  = (state == ST_LOCK) && in_valid[ptr];
        bcnt_nxt  = bcnt + 4'd1;
        win       = lock_hit ? ptr : rr_win;
        win_found = lock_hit || rr_found;
    end

    // Burst FSM: a fresh grant opens a lock, MAX_BURST beats or an idle owner closes it; stalls freeze it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            bcnt  <= 4'd0;
        end else if (load) begin
            if (lock_hit) begin
                if (bcnt_nxt == 4'(MAX_BURST)) begin
                    state <= ST_IDLE;
                    bcnt  <= 4'd0;
                end else begin
                    bcnt  <= bcnt_nxt;
                end
            end else if (xfer) begin
                // New owner chosen by round-robin, possibly in the same cycle the old lock ended.
                if (MAX_BURST == 1) begin
                    state <= ST_IDLE;
                    bcnt  <= 4'd0;
                end else begin
                    state <= ST_LOCK;
                    bcnt  <= 4'd1;
                end
            end else begin
                state <= ST_IDLE;
                bcnt  <= 4'd0;
            end
        end
    end
`else
    // Plain per-beat round-robin.
    always_comb begin
        win       = rr_win;
        win_found = rr_found;
    end
`endif

    // Grant is one-hot to the winner only when the output register can load and reset is low.
    always_comb begin
        xfer     = !rst && load && win_found;
        in_ready = '0;
        if (xfer) begin
            in_ready[win] = 1'b1;
        end
    end

    // Select the winning requester's beat for the output register.
    always_comb begin
        win_data = in_data[int'(win)*DW +: DW];
    end

    // Output register and priority pointer; data/src hold when no beat is loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= SW'(NUM_REQ - 1);
        end else if (load) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= win_data;
                out_src   <= win;
                ptr       <= win;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hs_rr_arbiter.sv
module tb_hs_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SW = 2;

    localparam logic [N*DW-1:0] D_IDX = 32'h03020100;
    localparam logic [N*DW-1:0] D_5A  = 32'h005A0000;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      in_valid;
    logic [N*DW-1:0]   in_data;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [SW-1:0]     out_src;
    logic              out_ready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hs_rr_arbiter #(.NUM_REQ(N), .DW(DW), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    // One row = inputs for one cycle plus the outputs expected during that cycle (before its rising edge).
    typedef struct {
        logic            rst;
        logic [N-1:0]    iv;
        logic [N*DW-1:0] id;
        logic            ordy;
        logic [N-1:0]    e_ir;
        logic            e_ov;
        logic [DW-1:0]   e_od;
        logic [SW-1:0]   e_os;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [N-1:0] iv, input logic [N*DW-1:0] id,
                       input logic ordy, input logic [N-1:0] e_ir, input logic e_ov,
                       input logic [DW-1:0] e_od, input logic [SW-1:0] e_os);
        vec_t v;
        v.rst = r;  v.iv = iv;  v.id = id;  v.ordy = ordy;
        v.e_ir = e_ir;  v.e_ov = e_ov;  v.e_od = e_od;  v.e_os = e_os;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        bit got;

        // Reset / idle / single requester.
        add(1, 4'b1111, D_IDX, 1, 4'b0000, 0, 8'h00, 0);   // in_ready forced low in reset
        add(0, 4'b0000, D_5A,  1, 4'b0000, 0, 8'h00, 0);
        add(0, 4'b0100, D_5A,  1, 4'b0100, 0, 8'h00, 0);
        add(0, 4'b0000, D_5A,  1, 4'b0000, 1, 8'h5A, 2);
        add(0, 4'b0000, D_5A,  1, 4'b0000, 0, 8'h5A, 2);   // idle: data/src hold
        add(1, 4'b0000, D_IDX, 1, 4'b0000, 0, 8'h5A, 2);
`ifdef ARB_BURST_LOCK_EN
        // Burst lock: four beats from 0, then 1; requester 1 drops after two beats.
        add(0, 4'b1111, D_IDX, 1, 4'b0001, 0, 8'h00, 0);
        add(0, 4'b1111, D_IDX, 1, 4'b0001, 1, 8'h00, 0);
        add(0, 4'b1111, D_IDX, 1, 4'b0001, 1, 8'h00, 0);
        add(0, 4'b1111, D_IDX, 1, 4'b0001, 1, 8'h00, 0);
        add(0, 4'b1111, D_IDX, 1, 4'b0010, 1, 8'h00, 0);
        add(0, 4'b1111, D_IDX, 1, 4'b0010, 1, 8'h01, 1);
        add(0, 4'b1101, D_IDX, 1, 4'b0100, 1, 8'h01, 1);
        add(0, 4'b1101, D_IDX, 1, 4'b0100, 1, 8'h02, 2);
        // Stall after first beat; lock and count hold through it.
        add(1, 4'b0000, D_IDX, 1, 4'b0000, 1, 8'h02, 2);
        add(0, 4'b1111, D_IDX, 1, 4'b0001, 0, 8'h00, 0);
        add(0, 4'b1111, D_IDX, 0, 4'b0000, 1, 8'h00, 0);
        add(0, 4'b1111, D_IDX, 0, 4'b0000, 1, 8'h00, 0);
        add(0, 4'b1111, D_IDX, 0, 4'b0000, 1, 8'h00, 0);
        add(0, 4'b1111, D_IDX, 1, 4'b0001, 1, 8'h00, 0);
        add(0, 4'b1111, D_IDX, 1, 4'b0001, 1, 8'h00, 0);
`else
        // Per-beat round-robin: 0,1,2,3,0,1 with ptr wrap and no idle cycles.
        add(0, 4'b1111, D_IDX, 1, 4'b0001, 0, 8'h00, 0);
        add(0, 4'b1111, D_IDX, 1, 4'b0010, 1, 8'h00, 0);
        add(0, 4'b1111, D_IDX, 1, 4'b0100, 1, 8'h01, 1);
        add(0, 4'b1111, D_IDX, 1, 4'b1000, 1, 8'h02, 2);
        add(0, 4'b1111, D_IDX, 1, 4'b0001, 1, 8'h03, 3);
        add(0, 4'b1111, D_IDX, 1, 4'b0010, 1, 8'h00, 0);
        add(0, 4'b1111, D_IDX, 1, 4'b0100, 1, 8'h01, 1);
        // Stall for 3 cycles after the first beat; sequence resumes at 1.
        add(1, 4'b0000, D_IDX, 1, 4'b0000, 1, 8'h02, 2);
        add(0, 4'b1111, D_IDX, 1, 4'b0001, 0, 8'h00, 0);
        add(0, 4'b1111, D_IDX, 0, 4'b0000, 1, 8'h00, 0);
        add(0, 4'b1111, D_IDX, 0, 4'b0000, 1, 8'h00, 0);
        add(0, 4'b1111, D_IDX, 0, 4'b0000, 1, 8'h00, 0);
        add(0, 4'b1111, D_IDX, 1, 4'b0010, 1, 8'h00, 0);
        add(0, 4'b1111, D_IDX, 1, 4'b0100, 1, 8'h01, 1);
`endif

        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);

        // Table-driven part: drive at falling edge, compare 1 time unit later.
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst       = tbl[i].rst;
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].id;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("row%0d in_ready",  i), 32'(in_ready),  32'(tbl[i].e_ir));
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("row%0d out_data",  i), 32'(out_data),  32'(tbl[i].e_od));
            chk($sformatf("row%0d out_src",   i), 32'(out_src),   32'(tbl[i].e_os));
        end

        // Reset during a stalled valid beat drops it; first grant afterwards goes to requester 0.
        @(negedge clk);
        rst = 1'b1;  in_valid = '0;  out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;  in_valid = 4'b1111;  in_data = D_IDX;  out_ready = 1'b1;
        #1 chk("pre_stall in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        out_ready = 1'b0;  in_valid = 4'b0110;
        #1 chk("stalled out_valid", 32'(out_valid), 32'h1);
        chk("stalled in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        rst = 1'b1;  out_ready = 1'b0;  in_valid = 4'b0110;
        #1 chk("in_reset out_valid", 32'(out_valid), 32'h1);
        chk("in_reset in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;  out_ready = 1'b0;  in_valid = 4'b1111;
        #1 chk("post_reset out_valid", 32'(out_valid), 32'h0);
        chk("post_reset in_ready", 32'(in_ready), 32'h1);
        out_ready = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) got = 1'b1;
        end
        chk("post_reset grant seen", 32'(got), 32'h1);
        chk("post_reset out_src", 32'(out_src), 32'h0);
        chk("post_reset out_data", 32'(out_data), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
